talon_stock_controller: RTL and testbench
=========================================

Name: talon_stock_controller

Overview:
- Sequences the talon (face-down draw pile) and stock (face-up waste pile) and owns both piles as register stacks.
- Arbitrates between the deal/setup logic (load), the player draw button (draw) and the move engine removing the visible stock card (take).
- Draw moves talon top to stock top. Draw with an empty talon recycles the stock back into the talon, one card per cycle.
- Sits between setup/deal logic, the input decoder, the move engine and the display.

Parameters:
CARD_SIZE, 6, bits per card encoding (0 = no card)
PILE_DEPTH, 24, max cards per pile; size ports are 5 bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
load  input  1  pulse; replace talon with load_pile/load_size, clear stock
load_pile  input  PILE_DEPTH*CARD_SIZE  talon contents, slot 0 = bottom
load_size  input  5  talon card count (<= PILE_DEPTH)
draw_req  input  1  level request, hold until draw_ack
draw_ack  output  1  one-cycle pulse, draw/recycle finished
draw_empty  output  1  valid with draw_ack; both piles were empty, no change
take_req  input  1  level request, hold until take_ack
take_ack  output  1  one-cycle pulse
take_card  output  CARD_SIZE  card removed, valid with take_ack; 0 if none
top_card  output  CARD_SIZE  current stock top; 0 when stock empty
talon_pile  output  PILE_DEPTH*CARD_SIZE  flat talon stack, unused slots 0
stock_pile  output  PILE_DEPTH*CARD_SIZE  flat stock stack, unused slots 0
talon_size  output  5  talon count
stock_size  output  5  stock count
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): piles all 0, sizes 0, acks 0, draw_empty 0, take_card 0, busy 0, state IDLE.
- Stack convention: slot 0 = bottom, top = slot size-1. Popped slot is written 0.
- States: IDLE, DRAW, RECYCLE, TAKE. Only IDLE accepts requests.
- Priority at a sampling edge: load > take > draw. Requests are ignored in the cycle where their own ack is high; this prevents a double grant.
- load: accepted in any state, synchronous. Aborts an in-flight op without an ack. At the next edge the talon = load_pile, talon_size = load_size, stock cleared, state IDLE.
- TAKE (IDLE, take_req, edge k): enter TAKE. At edge k+1:
  - pop the stock top into take_card and pulse take_ack;
  - if the stock was empty, take_card = 0 and no change;
  - return to IDLE.
- DRAW (IDLE, draw_req, talon_size>0, edge k): enter DRAW with count = 1. Each following edge moves talon top to stock top and decrements count. When count reaches 0, pulse draw_ack and return to IDLE. Single draw acks after edge k+1.
- RECYCLE (IDLE, draw_req, talon_size==0, stock_size>0): each edge pops stock top and pushes it onto talon.
  - After stock_size moves, pulse draw_ack and return to IDLE.
  - Resulting order: the first-drawn card is back on talon top. An N-card recycle takes N cycles.
- Both empty, draw_req in IDLE: next edge pulses draw_ack with draw_empty=1, no state change.
- Sizes never wrap: a push at PILE_DEPTH or a pop at 0 is suppressed. Pile contents stay unchanged; the op still completes.
- top_card, sizes and piles are registered and reflect the state after each edge.

Optional Feature:
DRAW_THREE_EN
- Defined: a draw sets count = min(3, talon_size) and moves that many cards, one per cycle. draw_ack comes after the last move. Recycle is unchanged.
- Undefined: count fixed at 1.

Test Plan:
- Reset mid-RECYCLE with rst_n low for 1 cycle -> sizes 0, busy 0, draw_ack never pulses.
- load_size=24 with cards 1..24 (slot i = i+1), then single draw -> 2 cycles after req, draw_ack=1, talon_size=23, stock_size=1, top_card=24.
- 24 draws then a further draw_req:
  - RECYCLE runs 24 cycles, busy high throughout, draw_ack then pulses once;
  - talon_size=24, stock_size=0, talon top = 24;
  - a further draw gives top_card=24.
- take_req and draw_req raised in the same cycle with stock_size=1, top 7 -> take wins: take_ack with take_card=7, stock_size=0. Draw is then served after the lockout cycle.
- Both piles empty, draw_req -> draw_ack with draw_empty=1, sizes unchanged. take_req -> take_ack with take_card=0.
- DRAW_THREE_EN, talon_size=2 -> 2 moves, draw_ack after 3 cycles, stock_size=2. Separately, load asserted mid-DRAW -> no ack, new load applied.

Source files
------------

// File: rtl/talon_stock_controller_if.sv
// Bundle of request, response and pile-view signals between the talon/stock
// controller (slave) and its surrounding deal, input, move and display logic (master).
interface talon_stock_controller_if #(
   parameter int unsigned CARD_SIZE  = 6,
   parameter int unsigned PILE_DEPTH = 24
);
   logic                             load;
   logic [PILE_DEPTH*CARD_SIZE-1:0]  load_pile;
   logic [4:0]                       load_size;
   logic                             draw_req;
   logic                             draw_ack;
   logic                             draw_empty;
   logic                             take_req;
   logic                             take_ack;
   logic [CARD_SIZE-1:0]             take_card;
   logic [CARD_SIZE-1:0]             top_card;
   logic [PILE_DEPTH*CARD_SIZE-1:0]  talon_pile;
   logic [PILE_DEPTH*CARD_SIZE-1:0]  stock_pile;
   logic [4:0]                       talon_size;
   logic [4:0]                       stock_size;
   logic                             busy;

   modport master (
      output load, load_pile, load_size, draw_req, take_req,
      input  draw_ack, draw_empty, take_ack, take_card, top_card,
             talon_pile, stock_pile, talon_size, stock_size, busy
   );

   modport slave (
      input  load, load_pile, load_size, draw_req, take_req,
      output draw_ack, draw_empty, take_ack, take_card, top_card,
             talon_pile, stock_pile, talon_size, stock_size, busy
   );
endinterface

// File: rtl/talon_stock_controller.sv
// Talon (draw pile) and stock (waste pile) sequencer owning both piles as register stacks.
// Slot 0 is the bottom of each stack; popped slots are cleared to 0.
// Optional macro DRAW_THREE_EN: a draw moves min(3, talon_size) cards instead of one.
module talon_stock_controller #(
   parameter int unsigned CARD_SIZE  = 6,
   parameter int unsigned PILE_DEPTH = 24
) (
   input logic                     clk,
   input logic                     rst_n,
   talon_stock_controller_if.slave bus
);
   localparam int unsigned SizeW = 5;
   localparam logic [SizeW-1:0] One  = SizeW'(1);
   localparam logic [SizeW-1:0] Full = SizeW'(PILE_DEPTH);

   typedef logic [CARD_SIZE-1:0] card_t;
   typedef enum logic [1:0] {StIdle, StDraw, StRecycle, StTake} state_e;

   state_e           state_q, state_d;
   card_t            talon_q [PILE_DEPTH];
   card_t            talon_d [PILE_DEPTH];
   card_t            stock_q [PILE_DEPTH];
   card_t            stock_d [PILE_DEPTH];
   logic [SizeW-1:0] talon_size_q, talon_size_d;
   logic [SizeW-1:0] stock_size_q, stock_size_d;
   logic [SizeW-1:0] count_q, count_d;
   logic [SizeW-1:0] load_n;
   logic             draw_ack_q, draw_ack_d;
   logic             draw_empty_q, draw_empty_d;
   logic             take_ack_q, take_ack_d;
   card_t            take_card_q, take_card_d;
   card_t            top_card_q, top_card_d;
   logic [PILE_DEPTH*CARD_SIZE-1:0] talon_flat, stock_flat;

   // Next-state: load override, request arbitration and one pile move per cycle.
   always_comb begin
      state_d      = state_q;
      talon_d      = talon_q;
      stock_d      = stock_q;
      talon_size_d = talon_size_q;
      stock_size_d = stock_size_q;
      count_d      = count_q;
      draw_ack_d   = 1'b0;
      draw_empty_d = 1'b0;
      take_ack_d   = 1'b0;
      take_card_d  = take_card_q;
      load_n       = (bus.load_size > Full) ? Full : bus.load_size;
      top_card_d   = '0;

      if (bus.load) begin
         // Load aborts whatever is in flight without acknowledging it.
         state_d = StIdle;
         count_d = '0;
         for (int i = 0; i < PILE_DEPTH; i++) begin
            talon_d[i] = (SizeW'(i) < load_n) ? bus.load_pile[i*CARD_SIZE +: CARD_SIZE] : '0;
            stock_d[i] = '0;
         end
         talon_size_d = load_n;
         stock_size_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Requests whose ack is still high are ignored to avoid a double grant.
               if (bus.take_req && !take_ack_q) begin
                  state_d = StTake;
               end else if (bus.draw_req && !draw_ack_q) begin
                  if (talon_size_q != '0) begin
                     state_d = StDraw;
`ifdef DRAW_THREE_EN
                     count_d = (talon_size_q < SizeW'(3)) ? talon_size_q : SizeW'(3);
`else
                     count_d = One;
`endif
                  end else if (stock_size_q != '0) begin
                     state_d = StRecycle;
                     count_d = stock_size_q;
                  end else begin
                     draw_ack_d   = 1'b1;
                     draw_empty_d = 1'b1;
                  end
               end
            end
            StTake: begin
               if (stock_size_q != '0) begin
                  take_card_d                  = stock_q[stock_size_q - One];
                  stock_d[stock_size_q - One]  = '0;
                  stock_size_d                 = stock_size_q - One;
               end else begin
                  take_card_d = '0;
               end
               take_ack_d = 1'b1;
               state_d    = StIdle;
            end
            StDraw: begin
               if (talon_size_q != '0 && stock_size_q != Full) begin
                  stock_d[stock_size_q]       = talon_q[talon_size_q - One];
                  talon_d[talon_size_q - One] = '0;
                  talon_size_d                = talon_size_q - One;
                  stock_size_d                = stock_size_q + One;
               end
               count_d = count_q - One;
               if (count_q <= One) begin
                  count_d    = '0;
                  draw_ack_d = 1'b1;
                  state_d    = StIdle;
               end
            end
            StRecycle: begin
               if (stock_size_q != '0 && talon_size_q != Full) begin
                  talon_d[talon_size_q]       = stock_q[stock_size_q - One];
                  stock_d[stock_size_q - One] = '0;
                  stock_size_d                = stock_size_q - One;
                  talon_size_d                = talon_size_q + One;
               end
               count_d = count_q - One;
               if (count_q <= One) begin
                  count_d    = '0;
                  draw_ack_d = 1'b1;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (stock_size_d != '0) begin
         top_card_d = stock_d[stock_size_d - One];
      end
   end

   // State and pile registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         for (int i = 0; i < PILE_DEPTH; i++) begin
            talon_q[i] <= '0;
            stock_q[i] <= '0;
         end
         talon_size_q <= '0;
         stock_size_q <= '0;
         count_q      <= '0;
         draw_ack_q   <= 1'b0;
         draw_empty_q <= 1'b0;
         take_ack_q   <= 1'b0;
         take_card_q  <= '0;
         top_card_q   <= '0;
      end else begin
         state_q      <= state_d;
         talon_q      <= talon_d;
         stock_q      <= stock_d;
         talon_size_q <= talon_size_d;
         stock_size_q <= stock_size_d;
         count_q      <= count_d;
         draw_ack_q   <= draw_ack_d;
         draw_empty_q <= draw_empty_d;
         take_ack_q   <= take_ack_d;
         take_card_q  <= take_card_d;
         top_card_q   <= top_card_d;
      end
   end

   // Flatten the stacks for the display view.
   always_comb begin
      talon_flat = '0;
      stock_flat = '0;
      for (int i = 0; i < PILE_DEPTH; i++) begin
         talon_flat[i*CARD_SIZE +: CARD_SIZE] = talon_q[i];
         stock_flat[i*CARD_SIZE +: CARD_SIZE] = stock_q[i];
      end
   end

   assign bus.draw_ack   = draw_ack_q;
   assign bus.draw_empty = draw_empty_q;
   assign bus.take_ack   = take_ack_q;
   assign bus.take_card  = take_card_q;
   assign bus.top_card   = top_card_q;
   assign bus.talon_pile = talon_flat;
   assign bus.stock_pile = stock_flat;
   assign bus.talon_size = talon_size_q;
   assign bus.stock_size = stock_size_q;
   assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_talon_stock_controller.sv
// Scoreboard bench for talon_stock_controller: expected ack responses are queued at issue time
// and checked by a separate monitor whenever draw_ack or take_ack is seen.
module tb_talon_stock_controller;
   localparam int CS = 6;
   localparam int PD = 24;
   localparam int W  = CS * PD;

   typedef struct {
      bit is_take;
      int card;
      int empty;
      int ts;
      int ss;
      int top;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   talon_stock_controller_if #(.CARD_SIZE(CS), .PILE_DEPTH(PD)) bus ();

   talon_stock_controller #(.CARD_SIZE(CS), .PILE_DEPTH(PD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic exp_t mk(input bit t, input int card, input int empty, input int ts,
                               input int ss, input int top);
      exp_t e;
      e.is_take = t;
      e.card    = card;
      e.empty   = empty;
      e.ts      = ts;
      e.ss      = ss;
      e.top     = top;
      return e;
   endfunction

   function automatic int slot(input logic [W-1:0] p, input int i);
      return int'(p[i*CS +: CS]);
   endfunction

   // Monitor: every ack must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (bus.draw_ack || bus.take_ack)) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ack: draw_ack=%0b take_ack=%0b, none pending",
                     bus.draw_ack, bus.take_ack);
         end else begin
            mon_e = sb.pop_front();
            chk("ack_kind_take", int'(bus.take_ack), int'(mon_e.is_take));
            chk("ack_kind_draw", int'(bus.draw_ack), int'(!mon_e.is_take));
            if (mon_e.is_take) chk("take_card", int'(bus.take_card), mon_e.card);
            else chk("draw_empty", int'(bus.draw_empty), mon_e.empty);
            chk("ack_talon_size", int'(bus.talon_size), mon_e.ts);
            chk("ack_stock_size", int'(bus.stock_size), mon_e.ss);
            chk("ack_top_card", int'(bus.top_card), mon_e.top);
         end
      end
   end

   // Issue one request, hold until its ack, report latency and busy cycles before the ack.
   task automatic req_op(input exp_t e, output int cyc, output int busy_cyc);
      logic ack;
      sb.push_back(e);
      @(negedge clk);
      if (e.is_take) bus.take_req = 1'b1;
      else bus.draw_req = 1'b1;
      cyc      = 0;
      busy_cyc = 0;
      ack      = 1'b0;
      while (!ack && cyc < 100) begin
         @(negedge clk);
         cyc++;
         ack = e.is_take ? bus.take_ack : bus.draw_ack;
         if (!ack && bus.busy) busy_cyc++;
      end
      if (!ack) begin
         n_checks++;
         $display("FAIL ack_timeout: no ack after %0d cycles, required within 100", cyc);
      end
      bus.take_req = 1'b0;
      bus.draw_req = 1'b0;
   endtask

   task automatic do_load(input logic [W-1:0] p, input int n);
      @(negedge clk);
      bus.load      = 1'b1;
      bus.load_pile = p;
      bus.load_size = 5'(n);
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc, bcyc, take_cyc, draw_cyc;
      logic [W-1:0] p;
      bus.load      = 1'b0;
      bus.load_pile = '0;
      bus.load_size = '0;
      bus.draw_req  = 1'b0;
      bus.take_req  = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_talon_size", int'(bus.talon_size), 0);
      chk("rst_stock_size", int'(bus.stock_size), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_top_card", int'(bus.top_card), 0);
      chk("rst_draw_ack", int'(bus.draw_ack), 0);
      chk("rst_take_ack", int'(bus.take_ack), 0);
      chk("rst_draw_empty", int'(bus.draw_empty), 0);
      chk("rst_take_card", int'(bus.take_card), 0);
      rst_n = 1'b1;

      // Both piles empty.
      req_op(mk(1'b0, 0, 1, 0, 0, 0), cyc, bcyc);
      chk("empty_draw_latency", cyc, 1);
      req_op(mk(1'b1, 0, 0, 0, 0, 0), cyc, bcyc);
      chk("empty_take_latency", cyc, 2);

      // Load during an in-flight draw aborts it without an ack.
      p = '0;
      for (int i = 0; i < 5; i++) p[i*CS +: CS] = 6'(i + 1);
      do_load(p, 5);
      @(negedge clk);
      bus.draw_req = 1'b1;
      @(negedge clk);
      chk("abort_busy_in_draw", int'(bus.busy), 1);
      p = '0;
      p[0 +: CS]  = 6'd9;
      p[CS +: CS] = 6'd10;
      bus.load      = 1'b1;
      bus.load_pile = p;
      bus.load_size = 5'd2;
      bus.draw_req  = 1'b0;
      @(negedge clk);
      bus.load = 1'b0;
      chk("abort_talon_size", int'(bus.talon_size), 2);
      chk("abort_stock_size", int'(bus.stock_size), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_talon_top", slot(bus.talon_pile, 1), 10);
      repeat (3) @(negedge clk);

`ifdef DRAW_THREE_EN
      req_op(mk(1'b0, 0, 0, 0, 2, 9), cyc, bcyc);
      chk("draw3_latency", cyc, 3);
`else
      req_op(mk(1'b0, 0, 0, 1, 1, 10), cyc, bcyc);
      chk("draw1_latency", cyc, 2);

      // Reset asserted for one cycle in the middle of a recycle.
      p = '0;
      for (int i = 0; i < 3; i++) p[i*CS +: CS] = 6'(i + 1);
      do_load(p, 3);
      for (int j = 1; j <= 3; j++) req_op(mk(1'b0, 0, 0, 3 - j, j, 4 - j), cyc, bcyc);
      @(negedge clk);
      bus.draw_req = 1'b1;
      @(negedge clk);
      chk("recycle_busy_before_rst", int'(bus.busy), 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      bus.draw_req = 1'b0;
      chk("midrst_talon_size", int'(bus.talon_size), 0);
      chk("midrst_stock_size", int'(bus.stock_size), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      repeat (5) @(negedge clk);

      // Full 24-card talon, draw everything, recycle.
      p = '0;
      for (int i = 0; i < PD; i++) p[i*CS +: CS] = 6'(i + 1);
      do_load(p, PD);
      chk("load24_talon_size", int'(bus.talon_size), 24);
      chk("load24_talon_top", slot(bus.talon_pile, 23), 24);
      req_op(mk(1'b0, 0, 0, 23, 1, 24), cyc, bcyc);
      chk("draw24_latency", cyc, 2);
      for (int j = 2; j <= PD; j++) req_op(mk(1'b0, 0, 0, 24 - j, j, 25 - j), cyc, bcyc);
      chk("stock_full_bottom", slot(bus.stock_pile, 0), 24);
      req_op(mk(1'b0, 0, 0, 24, 0, 0), cyc, bcyc);
      chk("recycle_busy_cycles", bcyc, 24);
      chk("recycle_latency", cyc, 25);
      chk("recycle_talon_top", slot(bus.talon_pile, 23), 24);
      chk("recycle_talon_bottom", slot(bus.talon_pile, 0), 1);
      req_op(mk(1'b0, 0, 0, 23, 1, 24), cyc, bcyc);

      // Simultaneous take and draw: take wins, draw follows.
      p = '0;
      p[0 +: CS]  = 6'd5;
      p[CS +: CS] = 6'd7;
      do_load(p, 2);
      req_op(mk(1'b0, 0, 0, 1, 1, 7), cyc, bcyc);
      sb.push_back(mk(1'b1, 7, 0, 1, 0, 0));
      sb.push_back(mk(1'b0, 0, 0, 0, 1, 5));
      @(negedge clk);
      bus.take_req = 1'b1;
      bus.draw_req = 1'b1;
      take_cyc = 0;
      draw_cyc = 0;
      for (int c = 1; c <= 50 && draw_cyc == 0; c++) begin
         @(negedge clk);
         if (bus.take_ack) begin
            take_cyc     = c;
            bus.take_req = 1'b0;
         end
         if (bus.draw_ack) begin
            draw_cyc     = c;
            bus.draw_req = 1'b0;
         end
      end
      bus.take_req = 1'b0;
      bus.draw_req = 1'b0;
      chk("prio_take_latency", take_cyc, 2);
      chk("prio_draw_after_take", int'(draw_cyc > take_cyc), 1);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
